// File: rtl/barra_generica.sv
// barra_generica: one player's paddle. Integrates vertical motion from
// up/down requests and runs a timed punch lunge toward the field centre
// with a symmetric ramp-up/ramp-down velocity profile.
// Optional feature macro: BARRA_RECARGA_EN adds a cooldown state (RECARGA)
// between the end of a punch and the next accepted request.
// The FSM state is exported on `estado` for observation.
module barra_generica #(
  parameter int unsigned LADO_DIREITO  = 0,
  parameter int unsigned LIMITE_CIMA   = 0,
  parameter int unsigned LIMITE_BAIXO  = 480,
  parameter int unsigned ALTURA        = 60,
  parameter int unsigned LIMIAR        = 2500000,
  parameter int unsigned VEL_V         = 1,
  parameter int unsigned TEMPO_GOLPE   = 5000000,
  parameter int unsigned N_FAIXAS      = 5,
  parameter int unsigned VEL_PASSO     = 10,
  parameter int unsigned TEMPO_RECARGA = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_inicial,
  input  logic [9:0] y_inicial,
  input  logic       mov_cima,
  input  logic       mov_baixo,
  input  logic       golpe_n,
  output logic [9:0] x_barra,
  output logic [9:0] y_barra,
  output logic [9:0] velocidade_golpe,
  output logic       golpe_ativo,
  output logic [1:0] estado
);

  // Velocity profile geometry: 2*N_FAIXAS slices of FAIXA_LEN cycles each.
  localparam int unsigned N_SLICES  = 2 * N_FAIXAS;
  localparam int unsigned FAIXA_LEN = (TEMPO_GOLPE / N_SLICES == 0) ? 1 : TEMPO_GOLPE / N_SLICES;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    INDO     = 2'd1,
`ifdef BARRA_RECARGA_EN
    VOLTANDO = 2'd2,
    RECARGA  = 2'd3
`else
    VOLTANDO = 2'd2
`endif
  } estado_t;

  estado_t     est;
  estado_t     est_next;
  logic [31:0] cont;
  logic [31:0] acc_h;
  logic [31:0] acc_v;
  logic [9:0]  x_base;
  logic        fim_fase;

`ifdef BARRA_RECARGA_EN
  logic [31:0] cont_rec;
  logic        fim_recarga;
  assign fim_recarga = (cont_rec + 32'd1) >= TEMPO_RECARGA;
`endif

  assign estado = est;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      est <= OCIOSO;
    end else begin
      est <= est_next;
    end
  end

  // Next-state logic; a punch phase ends on its last counted cycle
  always_comb begin
    est_next    = est;
    golpe_ativo = 1'b0;
    fim_fase    = (cont + 32'd1) >= TEMPO_GOLPE;
    case (est)
      OCIOSO: begin
        if (!golpe_n) est_next = INDO;
      end
      INDO: begin
        golpe_ativo = 1'b1;
        if (fim_fase) est_next = VOLTANDO;
      end
      VOLTANDO: begin
        golpe_ativo = 1'b1;
`ifdef BARRA_RECARGA_EN
        if (fim_fase) est_next = RECARGA;
`else
        if (fim_fase) est_next = OCIOSO;
`endif
      end
`ifdef BARRA_RECARGA_EN
      RECARGA: begin
        if (fim_recarga) est_next = OCIOSO;
      end
`endif
      default: est_next = OCIOSO;
    endcase
  end

  // Punch velocity: ramps up over the first half of the slices, mirrors down
  logic [31:0] faixa;
  logic [31:0] faixa_sat;
  logic [31:0] faixa_espelho;
  logic [31:0] faixa_menor;
  always_comb begin
    faixa            = cont / FAIXA_LEN;
    faixa_sat        = (faixa > N_SLICES - 1) ? N_SLICES - 1 : faixa;
    faixa_espelho    = (N_SLICES - 1) - faixa_sat;
    faixa_menor      = (faixa_sat < faixa_espelho) ? faixa_sat : faixa_espelho;
    velocidade_golpe = 10'd0;
    if (golpe_ativo) velocidade_golpe = 10'(VEL_PASSO * (faixa_menor + 32'd1));
  end

  // Horizontal step decision: toward the centre while going out, away on return
  logic [31:0] soma_h;
  logic        passo_h;
  logic        sentido_mais;
  always_comb begin
    soma_h       = acc_h + 32'(velocidade_golpe);
    passo_h      = soma_h >= LIMIAR;
    sentido_mais = (est == INDO) ^ (LADO_DIREITO != 0);
  end

  // Horizontal datapath: phase counter, sub-pixel accumulator, x position.
  // The exit of the return phase snaps x home so rounding never drifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_base  <= x_inicial;
      x_barra <= x_inicial;
      cont    <= '0;
      acc_h   <= '0;
    end else if (golpe_ativo) begin
      if (fim_fase) begin
        cont  <= '0;
        acc_h <= '0;
        if (est == VOLTANDO) x_barra <= x_base;
      end else begin
        cont <= cont + 32'd1;
        if (passo_h) begin
          acc_h   <= soma_h - LIMIAR;
          x_barra <= sentido_mais ? x_barra + 10'd1 : x_barra - 10'd1;
        end else begin
          acc_h <= soma_h;
        end
      end
    end else begin
      cont  <= '0;
      acc_h <= '0;
    end
  end

  // Vertical step decision: conflicting requests hold, limits are respected
  logic [31:0] soma_v;
  logic        passo_v;
  logic        pode_subir;
  logic        pode_descer;
  always_comb begin
    soma_v      = acc_v + VEL_V;
    passo_v     = soma_v >= LIMIAR;
    pode_subir  = 32'(y_barra) > LIMITE_CIMA;
    pode_descer = (32'(y_barra) + ALTURA) < LIMITE_BAIXO;
  end

  // Vertical datapath: free-running accumulator paces the y steps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_v   <= '0;
      y_barra <= y_inicial;
    end else if (passo_v) begin
      acc_v <= soma_v - LIMIAR;
      if (mov_cima && !mov_baixo && pode_subir) begin
        y_barra <= y_barra - 10'd1;
      end else if (mov_baixo && !mov_cima && pode_descer) begin
        y_barra <= y_barra + 10'd1;
      end
    end else begin
      acc_v <= soma_v;
    end
  end

`ifdef BARRA_RECARGA_EN
  // Cooldown counter, only running while in RECARGA
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cont_rec <= '0;
    end else if (est == RECARGA) begin
      cont_rec <= cont_rec + 32'd1;
    end else begin
      cont_rec <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_barra_generica.sv
// Testbench for barra_generica: a left and a right paddle share the same
// stimulus. A table of per-cycle vectors covers reset and one full punch;
// hand-written sequences cover vertical limits, re-arm timing and an
// asynchronous reset in the middle of a punch.
module tb_barra_generica;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] x_inicial;
  logic [9:0] y_inicial;
  logic       mov_cima;
  logic       mov_baixo;
  logic       golpe_n;

  logic [9:0] x_esq, y_esq, vel_esq;
  logic [9:0] x_dir, y_dir, vel_dir;
  logic       ativo_esq, ativo_dir;
  logic [1:0] est_esq, est_dir;

  barra_generica #(
    .LADO_DIREITO(0), .LIMITE_CIMA(0), .LIMITE_BAIXO(480), .ALTURA(60),
    .LIMIAR(10), .VEL_V(5), .TEMPO_GOLPE(20), .N_FAIXAS(2), .VEL_PASSO(5),
    .TEMPO_RECARGA(8)
  ) u_esq (
    .clk(clk), .reset(reset), .x_inicial(x_inicial), .y_inicial(y_inicial),
    .mov_cima(mov_cima), .mov_baixo(mov_baixo), .golpe_n(golpe_n),
    .x_barra(x_esq), .y_barra(y_esq), .velocidade_golpe(vel_esq),
    .golpe_ativo(ativo_esq), .estado(est_esq)
  );

  barra_generica #(
    .LADO_DIREITO(1), .LIMITE_CIMA(0), .LIMITE_BAIXO(480), .ALTURA(60),
    .LIMIAR(10), .VEL_V(5), .TEMPO_GOLPE(20), .N_FAIXAS(2), .VEL_PASSO(5),
    .TEMPO_RECARGA(8)
  ) u_dir (
    .clk(clk), .reset(reset), .x_inicial(x_inicial), .y_inicial(y_inicial),
    .mov_cima(mov_cima), .mov_baixo(mov_baixo), .golpe_n(golpe_n),
    .x_barra(x_dir), .y_barra(y_dir), .velocidade_golpe(vel_dir),
    .golpe_ativo(ativo_dir), .estado(est_dir)
  );

  // Scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nome, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
    end
  endtask

  // Vector table: inputs for one clock edge and the outputs expected after it
  typedef struct {
    logic       rst;
    logic       gn;
    logic [9:0] xi;
    logic [9:0] exp_xl;
    logic [9:0] exp_xr;
    logic [9:0] exp_y;
    logic [9:0] exp_vel;
    logic       exp_ativo;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic gn, input logic [9:0] xi,
                              input logic [9:0] xl, input logic [9:0] xr,
                              input logic [9:0] vel, input logic ativo);
    vec_t v;
    v.rst       = rst;
    v.gn        = gn;
    v.xi        = xi;
    v.exp_xl    = xl;
    v.exp_xr    = xr;
    v.exp_y     = 10'd200;
    v.exp_vel   = vel;
    v.exp_ativo = ativo;
    return v;
  endfunction

  // Velocity per 5-cycle slice: L = 20/(2*2) = 5, i = cont/5, 5*(min(i,3-i)+1)
  int prof [4] = '{5, 10, 10, 5};

  vec_t tab [43];

  // Driver: reset with the given home position, all requests released
  task automatic do_reset(input logic [9:0] xi, input logic [9:0] yi);
    @(negedge clk);
    reset     = 1'b1;
    x_inicial = xi;
    y_inicial = yi;
    mov_cima  = 1'b0;
    mov_baixo = 1'b0;
    golpe_n   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s;
    int k;
    int w;
    int dur;
    int gap;
    logic       gn;
    logic [9:0] xi;
    logic [9:0] gap_exp;

    reset     = 1'b1;
    x_inicial = 10'd100;
    y_inicial = 10'd200;
    mov_cima  = 1'b0;
    mov_baixo = 1'b0;
    golpe_n   = 1'b1;

    // Table: reset, then edge E_j (j=0..40) of a single punch.
    // INDO accumulates on cont 0..18 only, so the outward travel is
    // floor(145/10) = 14 pixels: 114 on the left, 86 on the right.
    tab[0] = mk(1'b1, 1'b1, 10'd100, 10'd100, 10'd100, 10'd0, 1'b0);
    for (int j = 0; j <= 40; j++) begin
      // golpe_n low at j=10 and j=40 falls outside OCIOSO and must be ignored;
      // x_inicial changes outside reset must not move the home position.
      gn = (j == 0 || j == 10 || j == 40) ? 1'b0 : 1'b1;
      xi = (j >= 5 && j <= 30) ? 10'd333 : 10'd100;
      if (j < 20) begin
        s = 0;
        for (int c = 0; c < j; c++) s += prof[c / 5];
        tab[1 + j] = mk(1'b0, gn, xi, 10'(100 + s / 10), 10'(100 - s / 10), 10'(prof[j / 5]), 1'b1);
      end else if (j < 40) begin
        k = j - 20;
        s = 0;
        for (int c = 0; c < k; c++) s += prof[c / 5];
        tab[1 + j] = mk(1'b0, gn, xi, 10'(114 - s / 10), 10'(86 + s / 10), 10'(prof[k / 5]), 1'b1);
      end else begin
        tab[1 + j] = mk(1'b0, gn, xi, 10'd100, 10'd100, 10'd0, 1'b0);
      end
    end
    tab[42] = mk(1'b0, 1'b1, 10'd100, 10'd100, 10'd100, 10'd0, 1'b0);

    for (int i = 0; i < 43; i++) begin
      @(negedge clk);
      reset     = tab[i].rst;
      golpe_n   = tab[i].gn;
      x_inicial = tab[i].xi;
      y_inicial = 10'd200;
      mov_cima  = 1'b0;
      mov_baixo = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("v%0d x_esq", i), x_esq, tab[i].exp_xl);
      check($sformatf("v%0d x_dir", i), x_dir, tab[i].exp_xr);
      check($sformatf("v%0d y_esq", i), y_esq, tab[i].exp_y);
      check($sformatf("v%0d y_dir", i), y_dir, tab[i].exp_y);
      check($sformatf("v%0d vel_esq", i), vel_esq, tab[i].exp_vel);
      check($sformatf("v%0d vel_dir", i), vel_dir, tab[i].exp_vel);
      check($sformatf("v%0d ativo_esq", i), 10'(ativo_esq), 10'(tab[i].exp_ativo));
      check($sformatf("v%0d ativo_dir", i), 10'(ativo_dir), 10'(tab[i].exp_ativo));
    end

    // Upper limit: acc_v reaches 10 on every second edge after reset release
    do_reset(10'd100, 10'd4);
    mov_cima = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("up e%0d y", e), y_esq, (4 - e / 2 < 0) ? 10'd0 : 10'(4 - e / 2));
    end
    mov_baixo = 1'b1;
    for (int e = 13; e <= 18; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("both e%0d y", e), y_esq, 10'd0);
    end
    mov_cima = 1'b0;
    for (int e = 19; e <= 24; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("down e%0d y", e), y_esq, 10'((e - 18) / 2));
    end

    // Lower limit: 420 + 60 = 480 is not strictly below 480, so 420 is the floor
    do_reset(10'd100, 10'd418);
    mov_baixo = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("low e%0d y", e), y_dir, (418 + e / 2 > 420) ? 10'd420 : 10'(418 + e / 2));
    end

    // golpe_n held low: latency, duration, home snap and re-arm gap
    do_reset(10'd100, 10'd200);
    golpe_n = 1'b0;
    w = 0;
    do begin
      @(posedge clk);
      #1;
      w++;
    end while (!ativo_esq && w < 5);
    check("hold rise latency", 10'(w), 10'd1);
    dur = 1;
    while (ativo_esq && dur < 100) begin
      @(posedge clk);
      #1;
      if (ativo_esq) dur++;
    end
    check("hold punch duration", 10'(dur), 10'd40);
    check("hold x_esq home", x_esq, 10'd100);
    check("hold x_dir home", x_dir, 10'd100);
`ifdef BARRA_RECARGA_EN
    gap_exp = 10'd9;
`else
    gap_exp = 10'd1;
`endif
    gap = 0;
    do begin
      @(posedge clk);
      #1;
      gap++;
    end while (!ativo_esq && gap < 30);
    check("hold rearm gap", 10'(gap), gap_exp);
    golpe_n = 1'b1;

    // Asynchronous reset at cycle 7 of INDO
    do_reset(10'd100, 10'd200);
    golpe_n = 1'b0;
    @(posedge clk);
    #1;
    golpe_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    // cont 0..6 accumulated 5*5 + 2*10 = 45 -> 4 pixels
    check("mid x_esq", x_esq, 10'd104);
    check("mid x_dir", x_dir, 10'd96);
    check("mid estado", 10'(est_esq), 10'd1);
    x_inicial = 10'd150;
    reset     = 1'b1;
    #1;
    check("areset x_esq", x_esq, 10'd150);
    check("areset x_dir", x_dir, 10'd150);
    check("areset y_esq", y_esq, 10'd200);
    check("areset vel", vel_esq, 10'd0);
    check("areset ativo", 10'(ativo_esq), 10'd0);
    check("areset estado_esq", 10'(est_esq), 10'd0);
    check("areset estado_dir", 10'(est_dir), 10'd0);
    @(negedge clk);
    reset = 1'b0;

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
